mem_port_arbiter: RTL and testbench

- Shares one memory port (req / ready_n / busy handshake) between the instruction-fetch stage and the memory-access stage.
- Grants one requester at a time, data side preferred, with an anti-starvation override for fetch.
- Registers the memory-side request and returns read data with a one-cycle ready pulse.
- Generates per-stage stall signals; sits between the pipeline stages and the external memory/cache.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the pipeline stages, the port arbiter and the memory.
// The arbiter takes the slave view; the pipeline/memory environment takes the master view.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        m_req;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready_n;
  logic        m_busy;
  logic        err;

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata,
    input  m_rdata, m_ready_n, m_busy,
    output i_rdata, i_ready, d_rdata, d_ready, stall_if, stall_mem,
    output m_req, m_write, m_size, m_addr, m_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata,
    output m_rdata, m_ready_n, m_busy,
    input  i_rdata, i_ready, d_rdata, d_ready, stall_if, stall_mem,
    input  m_req, m_write, m_size, m_addr, m_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access: data preferred,
// fetch forced after STARVE_LIMIT consecutive data grants, timeout abort with err pulse.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [3:0]  starve_cnt_r, starve_cnt_s;
  logic [7:0]  timer_r, timer_s;
  logic        m_req_r, m_req_s;
  logic        m_write_r, m_write_s;
  logic [1:0]  m_size_r, m_size_s;
  logic [31:0] m_addr_r, m_addr_s;
  logic [31:0] m_wdata_r, m_wdata_s;
  logic [31:0] i_rdata_r, i_rdata_s;
  logic [31:0] d_rdata_r, d_rdata_s;
  logic        i_ready_r, i_ready_s;
  logic        d_ready_r, d_ready_s;
  logic        err_r, err_s;
  logic        take_fetch_s;

  // Fetch wins when data is idle or fetch has waited through STARVE_LIMIT data grants.
  assign take_fetch_s = bus.i_req & (~bus.d_req | (starve_cnt_r == STARVE_MAX));

  // Next-state and next-output logic for the grant FSM.
  always_comb begin
    state_s      = state_r;
    starve_cnt_s = starve_cnt_r;
    timer_s      = timer_r;
    m_req_s      = m_req_r;
    m_write_s    = m_write_r;
    m_size_s     = m_size_r;
    m_addr_s     = m_addr_r;
    m_wdata_s    = m_wdata_r;
    i_rdata_s    = i_rdata_r;
    d_rdata_s    = d_rdata_r;
    i_ready_s    = 1'b0;
    d_ready_s    = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.m_busy) begin
          state_s = IDLE;
        end else if (take_fetch_s) begin
          state_s      = GRANT_I;
          timer_s      = 8'd0;
          starve_cnt_s = 4'd0;
          m_req_s      = 1'b1;
          m_write_s    = 1'b0;
          m_size_s     = 2'b10;
          m_addr_s     = bus.i_addr;
          m_wdata_s    = 32'h0000_0000;
        end else if (bus.d_req) begin
          state_s   = GRANT_D;
          timer_s   = 8'd0;
          m_req_s   = 1'b1;
          m_write_s = bus.d_write;
          m_size_s  = bus.d_size;
          m_addr_s  = bus.d_addr;
          m_wdata_s = bus.d_wdata;
          if (bus.i_req && (starve_cnt_r < STARVE_MAX)) begin
            starve_cnt_s = starve_cnt_r + 4'd1;
          end else begin
            starve_cnt_s = starve_cnt_r;
          end
        end else begin
          state_s = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        // Completion takes priority over timeout; m_busy is irrelevant once granted.
        if (!bus.m_ready_n) begin
          m_req_s = 1'b0;
          state_s = DONE;
          if (state_r == GRANT_I) begin
            i_ready_s = 1'b1;
            i_rdata_s = bus.m_rdata;
          end else begin
            d_ready_s = 1'b1;
            if (!m_write_r) begin
              d_rdata_s = bus.m_rdata;
            end else begin
              d_rdata_s = d_rdata_r;
            end
          end
        end else if (timer_r == TIMER_LAST) begin
          m_req_s = 1'b0;
          err_s   = 1'b1;
          state_s = DONE;
          if (state_r == GRANT_I) begin
            i_ready_s = 1'b1;
          end else begin
            d_ready_s = 1'b1;
          end
        end else begin
          timer_s = timer_r + 8'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        m_req_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update; reset drops m_req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      starve_cnt_r <= 4'd0;
      timer_r      <= 8'd0;
      m_req_r      <= 1'b0;
      m_write_r    <= 1'b0;
      m_size_r     <= 2'b00;
      m_addr_r     <= 32'h0000_0000;
      m_wdata_r    <= 32'h0000_0000;
      i_rdata_r    <= 32'h0000_0000;
      d_rdata_r    <= 32'h0000_0000;
      i_ready_r    <= 1'b0;
      d_ready_r    <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      starve_cnt_r <= starve_cnt_s;
      timer_r      <= timer_s;
      m_req_r      <= m_req_s;
      m_write_r    <= m_write_s;
      m_size_r     <= m_size_s;
      m_addr_r     <= m_addr_s;
      m_wdata_r    <= m_wdata_s;
      i_rdata_r    <= i_rdata_s;
      d_rdata_r    <= d_rdata_s;
      i_ready_r    <= i_ready_s;
      d_ready_r    <= d_ready_s;
      err_r        <= err_s;
    end
  end

  assign bus.m_req     = m_req_r;
  assign bus.m_write   = m_write_r;
  assign bus.m_size    = m_size_r;
  assign bus.m_addr    = m_addr_r;
  assign bus.m_wdata   = m_wdata_r;
  assign bus.i_rdata   = i_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.i_ready   = i_ready_r;
  assign bus.d_ready   = d_ready_r;
  assign bus.err       = err_r;
  assign bus.stall_if  = bus.i_req & ~i_ready_r;
  assign bus.stall_mem = bus.d_req & ~d_ready_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, starvation, store, busy,
// timeout and asynchronous reset, all against hand-computed expectations.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  logic resp_en;
  int   checks;
  int   errors;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_LIMIT(4),
    .TIMEOUT     (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample 1 time unit after the edge, then the memory model answers
  // the next edge with m_ready_n low whenever a request is outstanding.
  task automatic step();
    @(posedge clk);
    #1;
    bus.m_ready_n = ~(bus.m_req & resp_en);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    resp_en       = 1'b1;
    rst           = 1'b1;
    bus.i_req     = 1'b0;
    bus.i_addr    = 32'h0;
    bus.d_req     = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_size    = 2'b00;
    bus.d_addr    = 32'h0;
    bus.d_wdata   = 32'h0;
    bus.m_rdata   = 32'h0;
    bus.m_ready_n = 1'b1;
    bus.m_busy    = 1'b0;
    step();
    step();
    check_eq("rst_m_req",   {31'd0, bus.m_req},   32'd0);
    check_eq("rst_m_addr",  bus.m_addr,           32'h0);
    check_eq("rst_m_size",  {30'd0, bus.m_size},  32'd0);
    check_eq("rst_i_ready", {31'd0, bus.i_ready}, 32'd0);
    check_eq("rst_d_ready", {31'd0, bus.d_ready}, 32'd0);
    check_eq("rst_err",     {31'd0, bus.err},     32'd0);
    check_eq("rst_d_rdata", bus.d_rdata,          32'h0);
    rst = 1'b0;

    // Fetch only
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h0000_0100;
    bus.m_rdata = 32'hDEAD_BEEF;
    #1;
    check_eq("f_stall_pre", {31'd0, bus.stall_if}, 32'd1);
    step();
    check_eq("f_m_req",   {31'd0, bus.m_req},    32'd1);
    check_eq("f_m_addr",  bus.m_addr,            32'h0000_0100);
    check_eq("f_m_size",  {30'd0, bus.m_size},   32'd2);
    check_eq("f_m_write", {31'd0, bus.m_write},  32'd0);
    check_eq("f_ready0",  {31'd0, bus.i_ready},  32'd0);
    check_eq("f_stall",   {31'd0, bus.stall_if}, 32'd1);
    step();
    check_eq("f_ready",   {31'd0, bus.i_ready},  32'd1);
    check_eq("f_rdata",   bus.i_rdata,           32'hDEAD_BEEF);
    check_eq("f_m_req0",  {31'd0, bus.m_req},    32'd0);
    check_eq("f_stall0",  {31'd0, bus.stall_if}, 32'd0);
    bus.i_req = 1'b0;
    step();
    check_eq("f_ready_end", {31'd0, bus.i_ready}, 32'd0);

    // Concurrent requests: data first, fetch next
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h0000_0104;
    bus.d_req   = 1'b1;
    bus.d_write = 1'b0;
    bus.d_addr  = 32'h0000_2000;
    bus.d_size  = 2'b10;
    bus.m_rdata = 32'h1234_5678;
    step();
    check_eq("c_m_addr_d", bus.m_addr,           32'h0000_2000);
    check_eq("c_m_size_d", {30'd0, bus.m_size},  32'd2);
    step();
    check_eq("c_d_ready",  {31'd0, bus.d_ready}, 32'd1);
    check_eq("c_d_rdata",  bus.d_rdata,          32'h1234_5678);
    check_eq("c_i_ready0", {31'd0, bus.i_ready}, 32'd0);
    check_eq("c_stall_if", {31'd0, bus.stall_if}, 32'd1);
    bus.d_req   = 1'b0;
    bus.m_rdata = 32'hCAFE_F00D;
    step();
    step();
    check_eq("c_m_addr_i", bus.m_addr,           32'h0000_0104);
    check_eq("c_m_req_i",  {31'd0, bus.m_req},   32'd1);
    step();
    check_eq("c_i_ready",  {31'd0, bus.i_ready}, 32'd1);
    check_eq("c_i_rdata",  bus.i_rdata,          32'hCAFE_F00D);
    bus.i_req = 1'b0;
    step();

    // Starvation: four data grants, one forced fetch, then data again
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h0000_0200;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h0000_3000;
    bus.m_rdata = 32'h55AA_55AA;
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq($sformatf("s_addr%0d", k), bus.m_addr, (k == 4) ? 32'h0000_0200 : 32'h0000_3000);
      step();
      check_eq($sformatf("s_iready%0d", k), {31'd0, bus.i_ready}, (k == 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("s_dready%0d", k), {31'd0, bus.d_ready}, (k == 4) ? 32'd0 : 32'd1);
      step();
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step();

    // Store leaves d_rdata alone
    bus.d_req   = 1'b1;
    bus.d_write = 1'b1;
    bus.d_wdata = 32'hA5A5_A5A5;
    bus.d_size  = 2'b00;
    bus.d_addr  = 32'h0000_4000;
    bus.m_rdata = 32'hFFFF_FFFF;
    step();
    check_eq("w_m_write", {31'd0, bus.m_write}, 32'd1);
    check_eq("w_m_wdata", bus.m_wdata,          32'hA5A5_A5A5);
    check_eq("w_m_size",  {30'd0, bus.m_size},  32'd0);
    check_eq("w_m_addr",  bus.m_addr,           32'h0000_4000);
    step();
    check_eq("w_d_ready", {31'd0, bus.d_ready}, 32'd1);
    check_eq("w_d_rdata", bus.d_rdata,          32'h55AA_55AA);
    bus.d_req   = 1'b0;
    bus.d_write = 1'b0;
    step();

    // Busy holds off the grant, then timeout abort
    bus.m_busy = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0000_5000;
    resp_en    = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq($sformatf("b_m_req%0d", k), {31'd0, bus.m_req}, 32'd0);
      check_eq($sformatf("b_stall%0d", k), {31'd0, bus.stall_mem}, 32'd1);
    end
    bus.m_busy = 1'b0;
    step();
    check_eq("b_grant",  {31'd0, bus.m_req}, 32'd1);
    check_eq("b_m_addr", bus.m_addr,         32'h0000_5000);
    for (int k = 1; k < 8; k++) begin
      step();
      check_eq($sformatf("t_err%0d", k),   {31'd0, bus.err},     32'd0);
      check_eq($sformatf("t_ready%0d", k), {31'd0, bus.d_ready}, 32'd0);
      check_eq($sformatf("t_m_req%0d", k), {31'd0, bus.m_req},   32'd1);
    end
    step();
    check_eq("t_err",     {31'd0, bus.err},     32'd1);
    check_eq("t_d_ready", {31'd0, bus.d_ready}, 32'd1);
    check_eq("t_m_req",   {31'd0, bus.m_req},   32'd0);
    check_eq("t_d_rdata", bus.d_rdata,          32'h55AA_55AA);
    bus.d_req = 1'b0;
    step();
    check_eq("t_err_end", {31'd0, bus.err}, 32'd0);

    // Asynchronous reset in the middle of a data grant
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0000_6000;
    step();
    check_eq("a_m_req", {31'd0, bus.m_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("a_m_req_rst", {31'd0, bus.m_req}, 32'd0);
    bus.d_req = 1'b0;
    step();
    check_eq("a_d_ready", {31'd0, bus.d_ready}, 32'd0);
    rst        = 1'b0;
    resp_en    = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0000_7000;
    bus.m_rdata = 32'h0BAD_F00D;
    step();
    check_eq("a_regrant", {31'd0, bus.m_req}, 32'd1);
    check_eq("a_m_addr",  bus.m_addr,         32'h0000_7000);
    step();
    check_eq("a_d_ready2", {31'd0, bus.d_ready}, 32'd1);
    check_eq("a_d_rdata",  bus.d_rdata,          32'h0BAD_F00D);
    bus.d_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
